// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
//   Registered Beta-style ALU with valid/ready handshakes on both sides and an
//   iterative shift-add multiplier. Single-cycle ops produce a result one
//   cycle after acceptance; MUL takes WIDTH+1 cycles. Status flags Z/V/N and
//   an illegal-opcode indication accompany every result.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : an operation is presented on alufn/a/b
//   in_ready   : the block accepts an operation this cycle
//   alufn[5:0] : opcode
//   a, b       : operands (WIDTH bits)
//   out_valid  : y and flags hold a result
//   out_ready  : consumer takes the result this cycle
//   y          : result (WIDTH bits)
//   z, v, n    : zero, signed overflow (ADD/SUB only), sign of y
//   illegal    : opcode not recognised; y forced to 0
// ----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alufn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    // Counter runs 0..WIDTH-1 for the shift-add steps; WIDTH marks the load cycle.
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    localparam logic [5:0] OP_CMPEQ = 6'b000011;
    localparam logic [5:0] OP_CMPLT = 6'b000101;
    localparam logic [5:0] OP_CMPLE = 6'b000111;
    localparam logic [5:0] OP_ADD   = 6'b010000;
    localparam logic [5:0] OP_SUB   = 6'b010001;
    localparam logic [5:0] OP_MUL   = 6'b010010;
    localparam logic [5:0] OP_AND   = 6'b101000;
    localparam logic [5:0] OP_OR    = 6'b101110;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_XNOR  = 6'b101001;
    localparam logic [5:0] OP_SHL   = 6'b110000;
    localparam logic [5:0] OP_SHR   = 6'b110001;
    localparam logic [5:0] OP_SRA   = 6'b110011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             v;
        logic             ill;
    } res_t;

    // Single-cycle result for every opcode except an enabled MUL.
    function automatic res_t alu_eval(input logic [5:0] fn,
                                      input logic signed [WIDTH-1:0] sa,
                                      input logic signed [WIDTH-1:0] sb);
        res_t             r;
        logic [WIDTH-1:0] ua;
        logic [WIDTH-1:0] ub;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] dif;
        logic [SHW-1:0]   sh;
        r   = '0;
        ua  = sa;
        ub  = sb;
        sum = ua + ub;
        dif = ua - ub;
        sh  = ub[SHW-1:0];
        case (fn)
            OP_CMPEQ: r.y = {{(WIDTH-1){1'b0}}, (ua == ub)};
            OP_CMPLT: r.y = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_CMPLE: r.y = {{(WIDTH-1){1'b0}}, (sa <= sb)};
            OP_ADD: begin
                r.y = sum;
                r.v = (ua[WIDTH-1] == ub[WIDTH-1]) && (sum[WIDTH-1] != ua[WIDTH-1]);
            end
            OP_SUB: begin
                r.y = dif;
                r.v = (ua[WIDTH-1] != ub[WIDTH-1]) && (dif[WIDTH-1] != ua[WIDTH-1]);
            end
            OP_AND:  r.y = ua & ub;
            OP_OR:   r.y = ua | ub;
            OP_XOR:  r.y = ua ^ ub;
            OP_XNOR: r.y = ~(ua ^ ub);
            OP_SHL:  r.y = ua << sh;
            OP_SHR:  r.y = ua >> sh;
            OP_SRA:  r.y = sa >>> sh;
            // With the multiplier disabled MUL falls through as illegal.
            OP_MUL:  r.ill = !MUL_EN;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             is_mul;
    logic             mul_load;
    res_t             res;

    // Gated by rst_n so nothing is offered while the block is held in reset.
    assign in_ready = rst_n && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (alufn == OP_MUL);
    assign mul_load = (state == S_MUL) && (cnt == CNT_LOAD);
    assign res      = alu_eval(alufn, a, b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && is_mul) state_nx = S_MUL;
            S_MUL:  if (mul_load)         state_nx = S_HOLD;
            S_HOLD: if (out_ready)        state_nx = S_IDLE;
            default:                      state_nx = S_IDLE;
        endcase
    end

    // Result stage: single-cycle ops load at the accepting edge, MUL at its
    // load cycle; otherwise the result drains when the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            z         <= 1'b0;
            v         <= 1'b0;
            n         <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept && !is_mul) begin
                out_valid <= 1'b1;
                y         <= res.y;
                z         <= (res.y == '0);
                v         <= res.v;
                n         <= res.y[WIDTH-1];
                illegal   <= res.ill;
            end else if (mul_load) begin
                out_valid <= 1'b1;
                y         <= acc;
                z         <= (acc == '0);
                v         <= 1'b0;
                n         <= acc[WIDTH-1];
                illegal   <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && is_mul)   cnt <= '0;
            else if (state == S_MUL) cnt <= cnt + CW'(1);
        end
    end

    // Multiplier datapath: one partial product per cycle, low WIDTH bits kept.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if ((state == S_MUL) && !mul_load) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    localparam logic [5:0] OP_CMPEQ = 6'b000011;
    localparam logic [5:0] OP_CMPLT = 6'b000101;
    localparam logic [5:0] OP_CMPLE = 6'b000111;
    localparam logic [5:0] OP_ADD   = 6'b010000;
    localparam logic [5:0] OP_SUB   = 6'b010001;
    localparam logic [5:0] OP_MUL   = 6'b010010;
    localparam logic [5:0] OP_AND   = 6'b101000;
    localparam logic [5:0] OP_OR    = 6'b101110;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_XNOR  = 6'b101001;
    localparam logic [5:0] OP_SHL   = 6'b110000;
    localparam logic [5:0] OP_SHR   = 6'b110001;
    localparam logic [5:0] OP_SRA   = 6'b110011;

    typedef struct packed {
        logic [5:0]  fn;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ey;
        logic        ez;
        logic        ev;
        logic        en;
        logic        eill;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alufn;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        z;
    logic        v;
    logic        n;
    logic        illegal;

    int tests;
    int fails;

    alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alufn(alufn), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .z(z), .v(v), .n(n), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Present one operation for a single edge, then leave the bench 1ns after it.
    task automatic issue(input logic [5:0] f, input logic [31:0] xa, input logic [31:0] xb);
        alufn    = f;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++;
        if (y !== 32'h0) begin fails++; $display("FAIL reset_y: got %h want 0", y); end
        tests++;
        if ({z, v, n, illegal} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got zvni=%b want 0000", {z, v, n, illegal}); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        vec_t tv[4];
        tv[0] = '{OP_ADD, 32'd15, 32'd13, 32'd28, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{OP_SUB, 32'd13, 32'd13, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2] = '{OP_SUB, 32'd13, 32'd15, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[3] = '{OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(tv[i].fn, tv[i].ea, tv[i].eb);
            tests++;
            if ({out_valid, y, z, v, n, illegal} !== {1'b1, tv[i].ey, tv[i].ez, tv[i].ev, tv[i].en, tv[i].eill}) begin
                fails++;
                $display("FAIL arith[%0d]: got vld=%b y=%h zvni=%b%b%b%b want vld=1 y=%h zvni=%b%b%b%b",
                         i, out_valid, y, z, v, n, illegal, tv[i].ey, tv[i].ez, tv[i].ev, tv[i].en, tv[i].eill);
            end
        end
    endtask

    task automatic test_logic();
        vec_t tv[8];
        tv[0] = '{OP_CMPEQ, 32'd13, 32'd13, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{OP_CMPLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2] = '{OP_CMPLE, 32'd15, 32'd13, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3] = '{OP_CMPLE, 32'd13, 32'd13, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4] = '{OP_AND, 32'd15, 32'd13, 32'd13, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5] = '{OP_OR, 32'd15, 32'd13, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6] = '{OP_XOR, 32'd15, 32'd13, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7] = '{OP_XNOR, 32'd15, 32'd13, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            issue(tv[i].fn, tv[i].ea, tv[i].eb);
            tests++;
            if ({out_valid, y, z, v, n, illegal} !== {1'b1, tv[i].ey, tv[i].ez, tv[i].ev, tv[i].en, tv[i].eill}) begin
                fails++;
                $display("FAIL logic[%0d]: got vld=%b y=%h zvni=%b%b%b%b want vld=1 y=%h zvni=%b%b%b%b",
                         i, out_valid, y, z, v, n, illegal, tv[i].ey, tv[i].ez, tv[i].ev, tv[i].en, tv[i].eill);
            end
        end
    endtask

    task automatic test_shift();
        vec_t tv[4];
        tv[0] = '{OP_SHL, 32'd15, 32'd4, 32'd240, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{OP_SHR, 32'hFFFFFFF0, 32'd4, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2] = '{OP_SRA, 32'hFFFFFFF0, 32'd4, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[3] = '{OP_SHL, 32'd1, 32'd36, 32'd16, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(tv[i].fn, tv[i].ea, tv[i].eb);
            tests++;
            if ({out_valid, y, z, v, n, illegal} !== {1'b1, tv[i].ey, tv[i].ez, tv[i].ev, tv[i].en, tv[i].eill}) begin
                fails++;
                $display("FAIL shift[%0d]: got vld=%b y=%h zvni=%b%b%b%b want vld=1 y=%h zvni=%b%b%b%b",
                         i, out_valid, y, z, v, n, illegal, tv[i].ey, tv[i].ez, tv[i].ev, tv[i].en, tv[i].eill);
            end
        end
    endtask

    task automatic test_mul();
        int bad;
        alufn    = OP_MUL;
        a        = 32'd7;
        b        = 32'hFFFFFFFD;
        in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL mul_accept_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bad = 0;
        // Cycles 0..32 after accept: busy, nothing valid yet.
        for (int k = 0; k < 33; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            if (k < 32) begin
                @(posedge clk);
                #1;
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL mul_busy: got %0d bad cycles want 0", bad); end
        @(posedge clk);
        #1;
        tests++;
        if ({out_valid, y, z, v, n, illegal} !== {1'b1, 32'hFFFFFFEB, 4'b0010}) begin
            fails++;
            $display("FAIL mul_result: got vld=%b y=%h zvni=%b%b%b%b want vld=1 y=ffffffeb zvni=0010",
                     out_valid, y, z, v, n, illegal);
        end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL mul_hold_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mul_drain: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        issue(OP_ADD, 32'd1, 32'd2);
        out_ready = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b1 || y !== 32'd3) begin fails++; $display("FAIL bp_first: got vld=%b y=%h want vld=1 y=3", out_valid, y); end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || y !== 32'd3 || in_ready !== 1'b0 || z !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL bp_stall: got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alufn    = OP_ADD;
            a        = 32'd10 + 32'(i);
            b        = 32'd1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || y !== 32'd11 + 32'(i)) begin
                fails++;
                $display("FAIL b2b[%0d]: got vld=%b y=%0d want vld=1 y=%0d", i, out_valid, y, 11 + i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got vld=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        issue(OP_ADD, 32'd2, 32'd3);
        issue(OP_MUL, 32'd7, 32'hFFFFFFFD);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, y, z, v, n, illegal, in_ready} !== 39'h0) begin
            fails++;
            $display("FAIL rst_mid_mul: got vld=%b y=%h zvni=%b%b%b%b rdy=%b want all 0",
                     out_valid, y, z, v, n, illegal, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL rst_no_result: got %0d valid cycles want 0", bad); end
        issue(OP_ADD, 32'd2, 32'd2);
        tests++;
        if (out_valid !== 1'b1 || y !== 32'd4 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL rst_add: got vld=%b y=%h ill=%b want vld=1 y=4 ill=0", out_valid, y, illegal);
        end
        issue(6'b111111, 32'd5, 32'd6);
        tests++;
        if ({out_valid, y, z, v, n, illegal} !== {1'b1, 32'h0, 4'b1001}) begin
            fails++;
            $display("FAIL illegal_op: got vld=%b y=%h zvni=%b%b%b%b want vld=1 y=0 zvni=1001",
                     out_valid, y, z, v, n, illegal);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alufn     = 6'b0;
        a         = 32'h0;
        b         = 32'h0;
        out_ready = 1'b1;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
